i2c_target_rx: RTL
==================

# i2c_target_rx

Write-only I2C target (slave) receiver that sits at the far end of the team's I2C write master. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address with the write bit, ACKs, and captures a two-byte payload (address, data1, data2, the same frame the master emits). The received 16-bit word is presented with a one-cycle valid strobe. It is used as an on-chip codec register model and as a loopback target for the master.

## Interface
- `TARGET_ADDR`, default 7'h1A: 7-bit address this target responds to.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  raw I2C clock from the pad; asynchronous to `clk`.
- `sda_in`  in  1  raw I2C data from the pad; asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `rx_data`  out  16  last completed payload, {data1, data2}, MSB first.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from an address-matched START to frame end.
- `nack_err`  out  1  one-cycle pulse when a third data byte is NACKed.

## Operation
- Inputs pass through a 2-flop synchronizer, then a third register for edge detection. Every decision uses synchronized values only.
- Bus events, evaluated every cycle:
  - START: SDA 1→0 while SCL = 1.
  - STOP: SDA 0→1 while SCL = 1.
  - Data is sampled on SCL rising edges.
  - `sda_oe` changes only on SCL falling edges, except on STOP and reset.
- FSM states: IDLE, ADDR, ACK_A, DATA1, ACK_1, DATA2, ACK_2, DONE, IGNORE.
- IDLE: START → ADDR. Clear the bit counter and shift register.
- ADDR: shift in 8 bits on SCL rises. At the SCL fall after bit 8:
  - If byte == {TARGET_ADDR, 1'b0}: go to ACK_A, set `sda_oe` = 1, `busy` = 1.
  - Otherwise (wrong address, or R/W = 1): go to IGNORE with `sda_oe` = 0.
- ACK_A / ACK_1 / ACK_2: hold `sda_oe` = 1 through the 9th SCL high. At the next SCL fall, release `sda_oe` and advance to DATA1 / DATA2 / DONE respectively.
- DATA1, DATA2: shift 8 bits MSB first. At the SCL fall after bit 8, latch the byte and enter the matching ACK state.
- On leaving ACK_2: `rx_data` ← {data1, data2}; pulse `rx_valid`.
- DONE: `sda_oe` stays 0 (NACK for any further byte). Count SCL rises. At the 8th rise, pulse `nack_err` once per frame. Remain in DONE until STOP or START.
- IGNORE: `sda_oe` = 0, `busy` = 0, no shifting. Exit only on START or STOP.
- STOP in any state → IDLE, `sda_oe` = 0 that same cycle, `busy` = 0. A partial payload is discarded and `rx_data` is unchanged.
- Repeated START in any state → ADDR. The partial payload is discarded and `busy` drops until the next address match.
- START/STOP takes priority over an SCL edge detected in the same cycle.
- Bit counter is 4 bits and counts 0..8. It is cleared on START and on each byte boundary.

## Timing
- Reset values: `sda_oe` = 0, `rx_data` = 16'h0000, `rx_valid` = 0, `busy` = 0, `nack_err` = 0, FSM in IDLE.
- Reset mid-frame releases SDA on the next `clk` edge. The target then ignores the bus until a fresh START.
- Pad-to-detect latency: 3 `clk` cycles. `sda_oe` rises 3–4 `clk` after the SCL pad falling edge.
- Minimum requirement: at least 8 `clk` per SCL phase (e.g. 50 MHz clk with 400 kHz SCL is well within this).
- `rx_valid` is asserted exactly 1 cycle after the SCL fall that ends ACK_2. It is never asserted twice per frame.
- `busy` rises in the same cycle `sda_oe` first asserts. It falls on STOP, START, or reset.

## Test plan
- Frame START, 0x34 (0x1A + W), 0xAB, 0xCD, STOP → three ACKs, `rx_data` = 16'hABCD, one `rx_valid` pulse, `busy` low after STOP.
- Address byte 0x36 (wrong address) → `sda_oe` never asserts, no `rx_valid`, `rx_data` unchanged.
- Address 0x35 (R/W = 1) → NACK, state IGNORE until STOP.
- START, 0x34, 0x12, repeated START, 0x34, 0x56, 0x78, STOP → `rx_data` = 16'h5678 with a single `rx_valid` pulse.
- Third data byte 0x99 after 0xABCD → NACK, one `nack_err` pulse, `rx_data` stays 16'hABCD.
- Assert `reset` during DATA1 while `sda_oe` = 0, and separately during ACK_A while `sda_oe` = 1 → `sda_oe` is 0 the next cycle, all outputs at reset values, and a subsequent clean frame 0x34/0x01/0x02 yields 16'h0102.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: synchronizes SCL/SDA, decodes START/STOP, ACKs a matching
// write address plus two data bytes and presents them as one 16-bit word.
module i2c_target_rx #(
   parameter logic [6:0] TARGET_ADDR = 7'h1A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        nack_err
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, DATA1, ACK_1, DATA2, ACK_2, DONE, IGNORE
   } state_t;

   state_t      state_reg, state_next;
   logic        scl_meta_reg, scl_sync_reg, scl_prev_reg;
   logic        sda_meta_reg, sda_sync_reg, sda_prev_reg;
   logic [3:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic [7:0]  data1_reg, data1_next;
   logic [7:0]  data2_reg, data2_next;
   logic [15:0] rx_data_reg, rx_data_next;
   logic        rx_valid_reg, rx_valid_next;
   logic        busy_reg, busy_next;
   logic        nack_err_reg, nack_err_next;
   logic        sda_oe_reg, sda_oe_next;

   logic start_det, stop_det, scl_rise, scl_fall;

   // Synchronizers reset to the idle-bus level so reset itself never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_meta_reg <= 1'b1;
         scl_sync_reg <= 1'b1;
         scl_prev_reg <= 1'b1;
         sda_meta_reg <= 1'b1;
         sda_sync_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_meta_reg <= scl_in;
         scl_sync_reg <= scl_meta_reg;
         scl_prev_reg <= scl_sync_reg;
         sda_meta_reg <= sda_in;
         sda_sync_reg <= sda_meta_reg;
         sda_prev_reg <= sda_sync_reg;
      end
   end

   assign start_det = scl_sync_reg &  sda_prev_reg & ~sda_sync_reg;
   assign stop_det  = scl_sync_reg & ~sda_prev_reg &  sda_sync_reg;
   assign scl_rise  =  scl_sync_reg & ~scl_prev_reg;
   assign scl_fall  = ~scl_sync_reg &  scl_prev_reg;

   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      data1_next    = data1_reg;
      data2_next    = data2_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      busy_next     = busy_reg;
      nack_err_next = 1'b0;
      sda_oe_next   = sda_oe_reg;

      // Bus conditions outrank any SCL edge seen in the same cycle.
      if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = 4'd0;
         shift_next   = 8'h00;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            ADDR, DATA1, DATA2: begin
               if (scl_rise && bit_cnt_reg != 4'd8) begin
                  shift_next   = {shift_reg[6:0], sda_sync_reg};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  if (state_reg == ADDR) begin
                     if (shift_reg == {TARGET_ADDR, 1'b0}) begin
                        state_next  = ACK_A;
                        sda_oe_next = 1'b1;
                        busy_next   = 1'b1;
                     end else begin
                        state_next  = IGNORE;
                        sda_oe_next = 1'b0;
                     end
                  end else if (state_reg == DATA1) begin
                     data1_next  = shift_reg;
                     state_next  = ACK_1;
                     sda_oe_next = 1'b1;
                  end else begin
                     data2_next  = shift_reg;
                     state_next  = ACK_2;
                     sda_oe_next = 1'b1;
                  end
               end
            end
            ACK_A, ACK_1, ACK_2: begin
               if (scl_fall) begin
                  sda_oe_next = 1'b0;
                  if (state_reg == ACK_A) begin
                     state_next = DATA1;
                  end else if (state_reg == ACK_1) begin
                     state_next = DATA2;
                  end else begin
                     state_next    = DONE;
                     rx_data_next  = {data1_reg, data2_reg};
                     rx_valid_next = 1'b1;
                  end
               end
            end
            DONE: begin
               // Counter saturates at 8, so the error pulse fires once per frame.
               if (scl_rise && bit_cnt_reg != 4'd8) begin
                  bit_cnt_next  = bit_cnt_reg + 4'd1;
                  nack_err_next = (bit_cnt_reg == 4'd7);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'h00;
         data1_reg    <= 8'h00;
         data2_reg    <= 8'h00;
         rx_data_reg  <= 16'h0000;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         nack_err_reg <= 1'b0;
         sda_oe_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         data1_reg    <= data1_next;
         data2_reg    <= data2_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         busy_reg     <= busy_next;
         nack_err_reg <= nack_err_next;
         sda_oe_reg   <= sda_oe_next;
      end
   end

   assign sda_oe   = sda_oe_reg;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign busy     = busy_reg;
   assign nack_err = nack_err_reg;
endmodule
